// File: rtl/stream_out_if.sv
`default_nettype none
// ============================================================================
//  Module      : stream_out_if
//  Description : Write-beat input and AXI-Stream output bundle of stream_out.
//                The master modport is the stream_out view (it masters the
//                AXIS side); the slave modport is the environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stream_out_if #(
   parameter int DATA_WIDTH = 32
);
   logic                    upsp_ac_wvalid;
   logic [DATA_WIDTH-1:0]   upsp_ac_wdata;
   logic                    ac_upsp_wready;
   logic                    m_axis_tvalid;
   logic                    m_axis_tready;
   logic [DATA_WIDTH-1:0]   m_axis_tdata;
   logic [DATA_WIDTH/8-1:0] m_axis_tstrb;
   logic [DATA_WIDTH/8-1:0] m_axis_tkeep;
   logic                    m_axis_tlast;
   logic                    m_axis_tuser;
   logic                    m_axis_tid;
   logic                    m_axis_tdest;

   modport master (
      input  upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
      output ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb,
             m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest
   );

   modport slave (
      output upsp_ac_wvalid, upsp_ac_wdata, m_axis_tready,
      input  ac_upsp_wready, m_axis_tvalid, m_axis_tdata, m_axis_tstrb,
             m_axis_tkeep, m_axis_tlast, m_axis_tuser, m_axis_tid, m_axis_tdest
   );
endinterface
`default_nettype wire

// File: rtl/stream_out.sv
`default_nettype none
// ============================================================================
//  Module      : stream_out
//  Description : AXI-Stream master returning Up-Sampling pixels to VDMA S2MM.
//                Output register plus skid stage, tuser on first pixel of a
//                frame, tlast on the last pixel of each row, frame_done pulse
//                once the whole destination frame has left.
//                Optional macro STREAM_OUT_STALL_CNT_EN enables the AXIS
//                backpressure counter on stall_cnt (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_out #(
   parameter int AXISOUT_DATA_WIDTH = 32,
   parameter int UPSP_WRDATA_WIDTH  = 32,
   parameter int DST_IMG_WIDTH      = 3840,
   parameter int DST_IMG_HEIGHT     = 2160
) (
   input  wire          clk,
   input  wire          rst_n,
   input  wire          UPSTART,
   stream_out_if.master bus,
   output logic         frame_done,
   output logic [31:0]  stall_cnt
);

   localparam int COL_W = (DST_IMG_WIDTH  > 1) ? $clog2(DST_IMG_WIDTH)  : 1;
   localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;
   localparam int TOTAL = DST_IMG_WIDTH * DST_IMG_HEIGHT;
   localparam int IN_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(DST_IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DST_IMG_HEIGHT - 1);
   localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(TOTAL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                        state_q, state_d;
   logic                          out_valid_q, out_valid_d;
   logic [AXISOUT_DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                          skid_valid_q, skid_valid_d;
   logic [UPSP_WRDATA_WIDTH-1:0]  skid_data_q, skid_data_d;
   logic [COL_W-1:0]              out_col_q, out_col_d;
   logic [ROW_W-1:0]              out_row_q, out_row_d;
   logic [IN_W-1:0]               in_cnt_q, in_cnt_d;
   logic                          in_all_q, in_all_d;
   logic                          frame_done_q, frame_done_d;

   logic wr_ready;
   logic wr_hs;
   logic ax_hs;
   logic start;
   logic last_beat;

   assign wr_ready  = (state_q == SEND) & ~skid_valid_q & ~in_all_q;
   assign wr_hs     = bus.upsp_ac_wvalid & wr_ready;
   assign ax_hs     = out_valid_q & bus.m_axis_tready;
   assign start     = (state_q == IDLE) & UPSTART;
   assign last_beat = ax_hs & (out_col_q == COL_LAST) & (out_row_q == ROW_LAST);

   // Next-state logic for the FSM, input accounting, position counters and buffers
   always_comb begin
      state_d      = state_q;
      in_cnt_d     = in_cnt_q;
      in_all_d     = in_all_q;
      out_col_d    = out_col_q;
      out_row_d    = out_row_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;

      case (state_q)
         IDLE:    if (UPSTART)   state_d = SEND;
         SEND:    if (last_beat) state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase

      // in_all latches on the final accepted beat; the counter stops there
      if (start) begin
         in_cnt_d = '0;
         in_all_d = 1'b0;
      end else if (wr_hs) begin
         if (in_cnt_q == IN_LAST) in_all_d = 1'b1;
         else                     in_cnt_d = in_cnt_q + 1'b1;
      end

      if (start) begin
         out_col_d = '0;
         out_row_d = '0;
      end else if (ax_hs) begin
         if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            out_row_d = (out_row_q == ROW_LAST) ? '0 : out_row_q + 1'b1;
         end else begin
            out_col_d = out_col_q + 1'b1;
         end
      end

      // Output register refills whenever it is empty or draining this cycle;
      // the skid entry has priority because it is older than the new beat.
      if (ax_hs || !out_valid_q) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = wr_hs;
            if (wr_hs) skid_data_d = bus.upsp_ac_wdata;
         end else if (wr_hs) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.upsp_ac_wdata;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (wr_hs) begin
         skid_valid_d = 1'b1;
         skid_data_d  = bus.upsp_ac_wdata;
      end

      frame_done_d = (state_d == DONE);
   end

   // State, counter and buffer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         in_cnt_q     <= '0;
         in_all_q     <= 1'b0;
         out_col_q    <= '0;
         out_row_q    <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_cnt_q     <= in_cnt_d;
         in_all_q     <= in_all_d;
         out_col_q    <= out_col_d;
         out_row_q    <= out_row_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign bus.ac_upsp_wready = wr_ready;
   assign bus.m_axis_tvalid  = out_valid_q;
   assign bus.m_axis_tdata   = out_data_q;
   assign bus.m_axis_tstrb   = '1;
   assign bus.m_axis_tkeep   = '1;
   assign bus.m_axis_tlast   = out_valid_q & (out_col_q == COL_LAST);
   assign bus.m_axis_tuser   = out_valid_q & (out_col_q == '0) & (out_row_q == '0);
   assign bus.m_axis_tid     = 1'b0;
   assign bus.m_axis_tdest   = 1'b0;
   assign frame_done         = frame_done_q;

`ifdef STREAM_OUT_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of cycles where a beat waits on AXIS backpressure
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (start)
         stall_cnt_d = '0;
      else if (out_valid_q && !bus.m_axis_tready && (stall_cnt_q != 32'hFFFF_FFFF))
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Backpressure counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/stream_out.md
Name: stream_out

Overview:
- AXI-Stream master that returns Up-Sampling output pixels to the VDMA S2MM channel.
- Accepts write beats from Up-Sampling through a valid/ready interface and buffers them in a 2-entry output register plus skid stage.
- Frames the stream: tuser on the first pixel of a frame, tlast on the last pixel of every row.
- Tracks row and column counts and reports when the whole destination frame has left.

Parameters:
- AXISOUT_DATA_WIDTH, 32, AXI-Stream tdata width in bits (multiple of 8).
- UPSP_WRDATA_WIDTH, 32, Up-Sampling write-data width; must equal AXISOUT_DATA_WIDTH.
- DST_IMG_WIDTH, 3840, pixels per output row.
- DST_IMG_HEIGHT, 2160, rows per output frame.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- UPSTART  input  1  start-of-frame request, level or pulse
- upsp_ac_wvalid  input  1  Up-Sampling write beat valid
- upsp_ac_wdata  input  UPSP_WRDATA_WIDTH  pixel data
- ac_upsp_wready  output  1  block can accept a write beat
- m_axis_tvalid  output  1  AXIS valid
- m_axis_tready  input  1  AXIS ready from VDMA
- m_axis_tdata  output  AXISOUT_DATA_WIDTH  pixel data
- m_axis_tstrb  output  AXISOUT_DATA_WIDTH/8  byte strobes, all ones
- m_axis_tkeep  output  AXISOUT_DATA_WIDTH/8  byte keeps, all ones
- m_axis_tlast  output  1  last pixel of row
- m_axis_tuser  output  1  first pixel of frame (start of frame)
- m_axis_tid  output  1  constant 0
- m_axis_tdest  output  1  constant 0
- frame_done  output  1  one-cycle pulse after the last frame beat handshakes
- stall_cnt  output  32  AXIS backpressure counter (see Optional Feature)

Behaviour:
Reset values:
- All outputs are 0 except m_axis_tstrb and m_axis_tkeep, which are all ones.
- FSM resets to IDLE; all counters and buffer valid bits reset to 0.

FSM:
- IDLE -> SEND when UPSTART=1.
- SEND -> DONE on the AXIS handshake (tvalid & tready) of the beat with out_col = DST_IMG_WIDTH-1 and out_row = DST_IMG_HEIGHT-1.
- DONE -> IDLE unconditionally after 1 cycle. frame_done=1 only in DONE.
- UPSTART is ignored outside IDLE.

Input side:
- ac_upsp_wready = (state==SEND) & ~skid_valid & ~in_all.
- in_all sets once DST_IMG_WIDTH*DST_IMG_HEIGHT write beats have been accepted; it clears on IDLE->SEND.
- A write handshake is wvalid & wready.

Buffer:
- Output register (out_valid/out_data) drives m_axis_*.
- On a write handshake: if the output register is empty or being drained this cycle, data loads the output register; otherwise it loads the skid register.
- When the output register drains and the skid register is valid, the skid data moves into the output register in the same cycle.
- Latency: 1 cycle from write handshake to tvalid.
- Sustains 1 beat/cycle when tready stays high.
- Never drops or duplicates a beat.
- Once asserted, m_axis_tvalid holds until the handshake, and tdata is stable while tvalid & ~tready.

Counters:
- out_col counts 0..DST_IMG_WIDTH-1 and out_row counts 0..DST_IMG_HEIGHT-1. Both advance only on AXIS handshakes.
- out_col wraps to 0 and out_row increments when out_col = DST_IMG_WIDTH-1.
- Both clear on IDLE->SEND.
- Widths are $clog2 of the respective parameter, with a minimum of 1.
- m_axis_tlast = out_valid & (out_col == DST_IMG_WIDTH-1).
- m_axis_tuser = out_valid & (out_col == 0) & (out_row == 0).
- These flags are combinational from the counters and describe the beat currently presented.

Boundary conditions:
- Simultaneous write-in and AXIS-out with the skid register valid: skid moves to the output register and the new beat loads skid. wready was 0 in that cycle, so this case cannot occur; a bench check asserts it never happens.
- wvalid while in IDLE or DONE: not accepted; wready=0.
- rst_n asserted mid-frame: the partial frame is discarded, the FSM returns to IDLE and tvalid deasserts immediately. The asynchronous reset is released synchronously to clk.
- DST_IMG_WIDTH=1: tlast is asserted on every beat.

Optional Feature:
Macro STREAM_OUT_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 each cycle with m_axis_tvalid & ~m_axis_tready. It saturates at 32'hFFFFFFFF, clears on IDLE->SEND, and resets to 0.
- Not defined: stall_cnt is tied to 0 and no counter logic is generated.

Test Plan:
1. Params W=4, H=2. UPSTART pulse, then 8 beats of data 0x10..0x17 with tready=1 held → beats appear 1 cycle after acceptance:
   - tuser only on 0x10;
   - tlast on 0x13 and 0x17;
   - frame_done pulses the cycle after the 0x17 handshake;
   - FSM returns to IDLE.
2. Same stream with tready toggling 1,0,0,1 repeating → all 8 beats in order, no loss or duplication, tdata stable during stalls, wready=0 whenever skid is full. With STREAM_OUT_STALL_CNT_EN defined, stall_cnt equals the number of tvalid&~tready cycles.
3. wvalid=1 with data 0xAA before UPSTART → wready=0 and no AXIS beat. After UPSTART the first beat is accepted and presented with tuser=1.
4. Ninth write beat offered after 8 accepted (W=4, H=2) → wready=0 (in_all). After the frame completes and a second UPSTART, the beat is accepted with tuser=1.
5. rst_n pulsed low after 5 of 8 beats → tvalid=0 and FSM in IDLE. A new frame then starts with out_col=0, out_row=0 and tuser on its first beat.
6. W=1, H=3 with 3 beats → tlast=1 on every beat, tuser only on the first beat, frame_done after the third handshake.
